ysyx_041461_mem_lsu: RTL
========================

Name: ysyx_041461_MEM_lsu

Overview:
Memory-access stage logic directly downstream of the MEM pipeline register. It consumes the MEM-register outputs (valid, exception, EXE result as address, MEM_ctrl, store data) and runs loads/stores over a valid/ready data-memory bus. It aligns, masks and sign/zero-extends the data, raises misalignment exceptions and stalls the pipeline (drives MEM enable low) while a transaction is outstanding. Its results feed the WB pipeline register.

Parameters:
ADDR_W, 64, width of the data-bus address.
DATA_W, 64, data-bus width; only 64 is supported.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous active-low reset; rst==0 resets immediately
lsu_valid_in  in  1  instruction in the MEM register is valid
lsu_exception_in  in  3  exception already carried by the instruction
lsu_addr_in  in  64  effective address (MEMreg EXE result)
lsu_store_data_in  in  64  forwarded rs2 value
lsu_MEM_ctrl_in  in  4  memory operation code
lsu_flush_in  in  1  kill from the control/CSR unit
dmem_req_valid  out  1  bus request valid
dmem_req_ready  in  1  bus accepts request
dmem_req_addr  out  64  address with bits [2:0] forced to 0
dmem_req_wen  out  1  1 = store
dmem_req_wdata  out  64  lane-shifted store data
dmem_req_wmask  out  8  byte strobes
dmem_resp_valid  in  1  read data / write ack valid
dmem_resp_rdata  in  64  raw 64-bit read word
lsu_busy  out  1  stall; drives MEM/EXE enables low
lsu_exception_out  out  3  exception forwarded to WB
lsu_load_data_out  out  64  extended load result
lsu_done  out  1  result valid for WB this cycle

Behaviour:
- Reset values: FSM=IDLE; dmem_req_valid=0, dmem_req_addr=0, dmem_req_wen=0, dmem_req_wdata=0, dmem_req_wmask=0; lsu_load_data_out=0; lsu_done=0; kill flag=0; lsu_exception_out=NOP.
- Op codes: NOP=0, LB=1, LH=2, LW=3, LD=4, LBU=5, LHU=6, LWU=7, SB=8, SH=9, SW=10, SD=11. Codes 12-15 are treated as NOP.
- Misaligned means a half-word access with addr[0]!=0, a word access with addr[1:0]!=0, or a double access with addr[2:0]!=0.
- Exception rule: if exception_in != NOP, pass it through and issue no access. Otherwise a misaligned load gives LOAD_MISALIGN (3'd4) and a misaligned store gives STORE_MISALIGN (3'd6). Otherwise the output is NOP. This path is combinational from the inputs in IDLE.
- start = IDLE & valid_in & mem op & exception_out==NOP & !flush_in.
- Non-memory op, or invalid/exception/flush in IDLE: zero-latency pass-through. lsu_done=valid_in & !flush_in, load_data=0, busy=0.
- IDLE: on start, latch the aligned address, wen, wmask, wdata and op, go to REQ. busy=1 combinationally in that same cycle.
- REQ: req_valid=1 with stable payload until req_ready. On req_ready, go to WAIT. req_valid and its payload must not change or drop before acceptance.
- WAIT: on resp_valid, register the extracted data (rdata >> 8*addr[2:0], then sign-extend for LB/LH/LW, zero-extend for LBU/LHU/LWU, full word for LD; 0 for stores) and go to DONE.
- DONE: busy=0; lsu_done=!kill for exactly one cycle; next state IDLE. Inputs are ignored in DONE so the same instruction is never re-issued.
- busy = start | REQ | WAIT.
- Store wmask: SB = 8'h01<<a, SH = 8'h03<<a, SW = 8'h0F<<a, SD = 8'hFF, where a = addr[2:0]. wdata = store_data << 8*a.
- Flush in REQ or WAIT sets the kill flag. The bus transaction still completes (no abort), busy is held, and DONE gives done=0. The kill flag clears on entering IDLE.
- req_ready and resp_valid in the same cycle while in REQ: the response is not accepted. The bus never responds before acceptance.
- Reset asserted mid-transaction returns all state to reset values immediately. The bus is reset together with this block.

Decomposition:
- Shared package / defines header: MEM_ctrl op codes, exception codes (NOP=0, LOAD_MISALIGN=4, STORE_MISALIGN=6), FSM state encodings (IDLE, REQ, WAIT, DONE).
- One sub-module: ysyx_041461_MEM_align. It is combinational and provides wmask/wdata generation, load extract/extend and the misalign check.

Test Plan:
- LW from addr 0x8000_0004, rdata 0x8765_4321_0000_0000 -> dmem_req_addr 0x8000_0000, load_data 0xFFFF_FFFF_8765_4321, done one cycle after resp.
- SB at addr 0x8000_0003, data 0xAB -> wmask 8'h08, wdata[31:24]=0xAB, wen=1, busy high from issue until DONE.
- LH at addr 0x8000_0001 -> exception_out 3'd4, no dmem_req_valid, done=1 same cycle, busy=0.
- req_ready held low 5 cycles -> req_valid and payload stable all 5 cycles, busy=1 throughout.
- Flush asserted in WAIT of LD -> response consumed, done=0 in DONE, FSM back to IDLE, next instruction issues normally.
- rst=0 asserted in WAIT -> req_valid=0, busy=0, done=0 immediately, no done pulse after release.

Source files
------------

// File: rtl/ysyx_041461_mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit:
// MEM_ctrl op codes, exception codes, FSM states and op-class helpers.
package ysyx_041461_mem_lsu_pkg;

   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LH  = 4'd2;
   localparam logic [3:0] OP_LW  = 4'd3;
   localparam logic [3:0] OP_LD  = 4'd4;
   localparam logic [3:0] OP_LBU = 4'd5;
   localparam logic [3:0] OP_LHU = 4'd6;
   localparam logic [3:0] OP_LWU = 4'd7;
   localparam logic [3:0] OP_SB  = 4'd8;
   localparam logic [3:0] OP_SH  = 4'd9;
   localparam logic [3:0] OP_SW  = 4'd10;
   localparam logic [3:0] OP_SD  = 4'd11;

   localparam logic [2:0] EXC_NOP            = 3'd0;
   localparam logic [2:0] EXC_LOAD_MISALIGN  = 3'd4;
   localparam logic [2:0] EXC_STORE_MISALIGN = 3'd6;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } lsu_state_e;

   function automatic logic is_load(input logic [3:0] op);
      return (op >= OP_LB) && (op <= OP_LWU);
   endfunction

   function automatic logic is_store(input logic [3:0] op);
      return (op >= OP_SB) && (op <= OP_SD);
   endfunction

endpackage

// File: rtl/ysyx_041461_mem_lsu_if.sv
// Data-memory valid/ready bus between the LSU (master) and memory (slave).
// Request: valid/ready/addr/wen/wdata/wmask. Response: valid/rdata.
interface ysyx_041461_mem_lsu_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   logic              dmem_req_valid;
   logic              dmem_req_ready;
   logic [ADDR_W-1:0] dmem_req_addr;
   logic              dmem_req_wen;
   logic [DATA_W-1:0] dmem_req_wdata;
   logic [7:0]        dmem_req_wmask;
   logic              dmem_resp_valid;
   logic [DATA_W-1:0] dmem_resp_rdata;

   modport master (
      output dmem_req_valid, dmem_req_addr, dmem_req_wen,
      output dmem_req_wdata, dmem_req_wmask,
      input  dmem_req_ready, dmem_resp_valid, dmem_resp_rdata
   );

   modport slave (
      input  dmem_req_valid, dmem_req_addr, dmem_req_wen,
      input  dmem_req_wdata, dmem_req_wmask,
      output dmem_req_ready, dmem_resp_valid, dmem_resp_rdata
   );
endinterface

// File: rtl/ysyx_041461_mem_lsu_align.sv
// Combinational lane logic: misalign check, store strobe/data shift
// (i_op/i_off/i_sdata) and load extract + extend (i_ld_op/i_ld_off/i_rdata).
module ysyx_041461_MEM_align
   import ysyx_041461_mem_lsu_pkg::*;
(
   input  logic [3:0]  i_op,
   input  logic [2:0]  i_off,
   input  logic [63:0] i_sdata,
   output logic        o_misalign,
   output logic [7:0]  o_wmask,
   output logic [63:0] o_wdata,
   input  logic [3:0]  i_ld_op,
   input  logic [2:0]  i_ld_off,
   input  logic [63:0] i_rdata,
   output logic [63:0] o_ldata
);

   logic [63:0] w_sh;

   always_comb begin
      o_misalign = 1'b0;
      case (i_op)
         OP_LH, OP_LHU, OP_SH: o_misalign = i_off[0];
         OP_LW, OP_LWU, OP_SW: o_misalign = |i_off[1:0];
         OP_LD, OP_SD:         o_misalign = |i_off;
         default: ;
      endcase
   end

   always_comb begin
      o_wmask = 8'h00;
      case (i_op)
         OP_SB: o_wmask = 8'h01 << i_off;
         OP_SH: o_wmask = 8'h03 << i_off;
         OP_SW: o_wmask = 8'h0F << i_off;
         OP_SD: o_wmask = 8'hFF;
         default: ;
      endcase
   end

   assign o_wdata = is_store(i_op) ? (i_sdata << {i_off, 3'b000}) : '0;

   assign w_sh = i_rdata >> {i_ld_off, 3'b000};

   always_comb begin
      o_ldata = '0;
      case (i_ld_op)
         OP_LB:  o_ldata = {{56{w_sh[7]}}, w_sh[7:0]};
         OP_LH:  o_ldata = {{48{w_sh[15]}}, w_sh[15:0]};
         OP_LW:  o_ldata = {{32{w_sh[31]}}, w_sh[31:0]};
         OP_LD:  o_ldata = w_sh;
         OP_LBU: o_ldata = {56'd0, w_sh[7:0]};
         OP_LHU: o_ldata = {48'd0, w_sh[15:0]};
         OP_LWU: o_ldata = {32'd0, w_sh[31:0]};
         default: ;
      endcase
   end

endmodule

// File: rtl/ysyx_041461_mem_lsu.sv
// MEM-stage load/store unit: issues one bus access per memory op, stalls
// the pipe while outstanding, and hands extended data/exception to WB.
module ysyx_041461_mem_lsu
   import ysyx_041461_mem_lsu_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              lsu_valid_in,
   input  logic [2:0]        lsu_exception_in,
   input  logic [ADDR_W-1:0] lsu_addr_in,
   input  logic [DATA_W-1:0] lsu_store_data_in,
   input  logic [3:0]        lsu_MEM_ctrl_in,
   input  logic              lsu_flush_in,
   ysyx_041461_mem_lsu_if.master dmem,
   output logic              lsu_busy,
   output logic [2:0]        lsu_exception_out,
   output logic [DATA_W-1:0] lsu_load_data_out,
   output logic              lsu_done
);

   lsu_state_e        r_state;
   logic              r_req_valid;
   logic [ADDR_W-1:0] r_addr;
   logic              r_wen;
   logic [DATA_W-1:0] r_wdata;
   logic [7:0]        r_wmask;
   logic [3:0]        r_op;
   logic [2:0]        r_off;
   logic              r_kill;
   logic [DATA_W-1:0] r_ldata;

   logic              w_misalign;
   logic [7:0]        w_wmask;
   logic [63:0]       w_wdata;
   logic [63:0]       w_ldata;
   logic              w_memop;
   logic              w_idle;
   logic [2:0]        w_exc;
   logic              w_start;

   ysyx_041461_MEM_align u_align (
      .i_op       (lsu_MEM_ctrl_in),
      .i_off      (lsu_addr_in[2:0]),
      .i_sdata    (lsu_store_data_in),
      .o_misalign (w_misalign),
      .o_wmask    (w_wmask),
      .o_wdata    (w_wdata),
      .i_ld_op    (r_op),
      .i_ld_off   (r_off),
      .i_rdata    (dmem.dmem_resp_rdata),
      .o_ldata    (w_ldata)
   );

   assign w_memop = is_load(lsu_MEM_ctrl_in)
                  | is_store(lsu_MEM_ctrl_in);
   assign w_idle  = (r_state == S_IDLE);

   // An incoming exception always wins over a new misalignment.
   always_comb begin
      w_exc = EXC_NOP;
      if (lsu_exception_in != EXC_NOP)
         w_exc = lsu_exception_in;
      else if (w_memop && w_misalign)
         w_exc = is_load(lsu_MEM_ctrl_in) ? EXC_LOAD_MISALIGN
                                          : EXC_STORE_MISALIGN;
   end

   assign w_start = w_idle & lsu_valid_in & w_memop
                  & (w_exc == EXC_NOP) & ~lsu_flush_in;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_req_valid <= 1'b0;
         r_addr      <= '0;
         r_wen       <= 1'b0;
         r_wdata     <= '0;
         r_wmask     <= 8'h00;
         r_op        <= OP_NOP;
         r_off       <= 3'd0;
         r_kill      <= 1'b0;
         r_ldata     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_kill <= 1'b0;
               if (w_start) begin
                  r_state     <= S_REQ;
                  r_req_valid <= 1'b1;
                  r_addr      <= {lsu_addr_in[ADDR_W-1:3], 3'b000};
                  r_wen       <= is_store(lsu_MEM_ctrl_in);
                  r_wdata     <= w_wdata;
                  r_wmask     <= w_wmask;
                  r_op        <= lsu_MEM_ctrl_in;
                  r_off       <= lsu_addr_in[2:0];
               end
            end
            S_REQ: begin
               if (lsu_flush_in) r_kill <= 1'b1;
               // A response seen together with acceptance is ignored.
               if (dmem.dmem_req_ready) begin
                  r_req_valid <= 1'b0;
                  r_state     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (lsu_flush_in) r_kill <= 1'b1;
               if (dmem.dmem_resp_valid) begin
                  r_ldata <= w_ldata;
                  r_state <= S_DONE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_kill  <= 1'b0;
            end
         endcase
      end
   end

   assign dmem.dmem_req_valid = r_req_valid;
   assign dmem.dmem_req_addr  = r_addr;
   assign dmem.dmem_req_wen   = r_wen;
   assign dmem.dmem_req_wdata = r_wdata;
   assign dmem.dmem_req_wmask = r_wmask;

   assign lsu_busy = w_start | (r_state == S_REQ) | (r_state == S_WAIT);

   assign lsu_exception_out = w_idle ? w_exc : EXC_NOP;

   assign lsu_load_data_out = (r_state == S_DONE) ? r_ldata : '0;

   // Pass-through completes in IDLE; a real access completes in DONE.
   assign lsu_done = (w_idle & lsu_valid_in & ~lsu_flush_in & ~w_start)
                   | ((r_state == S_DONE) & ~r_kill);

endmodule
